// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan driver: hex glyph table,
// polarity-dependent "all off" values and the scan state encoding.
package seg_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } state_t;

  // Active-high {g,f,e,d,c,b,a} glyphs for nibble values 0..F.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [7:0] seg_off(input bit active_low);
    return active_low ? 8'hFF : 8'h00;
  endfunction

  function automatic logic [7:0] an_off(input bit active_low);
    return active_low ? 8'hFF : 8'h00;
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational nibble to active-high seven-segment glyph; shared with the
// LED debug path.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = HEX_SEG[i_nibble];

endmodule

// File: rtl/seg_scan.sv
// Time-multiplexed 8-digit hex display driver with a one-clock dead time
// between digits and tear-free updates that land only at frame wrap.
module seg_scan
  import seg_pkg::*;
#(
  parameter int DIGITS     = 8,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scan_src,
  input  logic              wr_en,
  input  logic [31:0]       wr_data,
  input  logic [7:0]        wr_dp,
  input  logic              blank_lz,
  output logic [DIGITS-1:0] an,
  output logic [7:0]        seg,
  output logic              pending
);

  localparam logic [7:0]        AN_OFF_ALL = an_off(ACTIVE_LOW);
  localparam logic [DIGITS-1:0] AN_OFF     = AN_OFF_ALL[DIGITS-1:0];
  localparam logic [7:0]        SEG_OFF    = seg_off(ACTIVE_LOW);
  localparam logic [2:0]        LAST_IDX   = 3'(DIGITS - 1);

  logic [2:0]        r_sync;
  logic              w_tick;
  state_t            r_state;
  state_t            w_state_nxt;
  logic [2:0]        r_idx;
  logic [2:0]        w_idx_nxt;
  logic              w_wrap;
  logic [31:0]       r_disp_data;
  logic [7:0]        r_disp_dp;
  logic [31:0]       r_shd_data;
  logic [7:0]        r_shd_dp;
  logic              r_pending;
  logic [DIGITS-1:0] r_an;
  logic [DIGITS-1:0] w_an_nxt;
  logic [7:0]        r_seg;
  logic [7:0]        w_seg_nxt;
  logic [3:0]        w_nibble;
  logic [6:0]        w_pattern;
  logic [7:0]        w_lz;
  logic              w_zero_run;
  logic [7:0]        w_an_ah;
  logic [7:0]        w_seg_ah;

  // scan_src is asynchronous: two flops resynchronise, the third remembers
  // the previous synchronised level for rising-edge detection.
  // NOTE: every clocked register uses non-blocking assignment so all flops
  // sample pre-edge values and simulation order cannot change behaviour.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sync <= 3'b000;
    else     r_sync <= {r_sync[1:0], scan_src};
  end

  assign w_tick = r_sync[1] & ~r_sync[2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= BLANK;
      r_idx   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  assign w_nibble = r_disp_data[{r_idx, 2'b00} +: 4];

  seg_hex_decode u_hex_decode (
    .i_nibble (w_nibble),
    .o_seg    (w_pattern)
  );

  // w_lz[i] is set when nibbles DIGITS-1 down to i are all zero; digit 0
  // is never a candidate.
  always_comb begin
    w_lz       = '0;
    w_zero_run = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      w_zero_run = w_zero_run & (r_disp_data[4*i +: 4] == 4'h0);
      w_lz[i]    = w_zero_run;
    end
  end

  assign w_an_ah  = 8'd1 << r_idx;
  // Blanking clears only g..a; the decimal point always follows its mask bit.
  assign w_seg_ah = {r_disp_dp[r_idx], (blank_lz & w_lz[r_idx]) ? 7'h00 : w_pattern};

  // NOTE: every signal driven here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_wrap      = 1'b0;
    w_an_nxt    = AN_OFF;
    w_seg_nxt   = SEG_OFF;
    case (r_state)
      BLANK: w_state_nxt = DRIVE;
      DRIVE: begin
        w_an_nxt  = ACTIVE_LOW ? ~w_an_ah[DIGITS-1:0] : w_an_ah[DIGITS-1:0];
        w_seg_nxt = ACTIVE_LOW ? ~w_seg_ah : w_seg_ah;
        if (w_tick) begin
          w_state_nxt = BLANK;
          w_wrap      = (r_idx == LAST_IDX);
          w_idx_nxt   = (r_idx == LAST_IDX) ? 3'd0 : r_idx + 3'd1;
        end
      end
      default: w_state_nxt = BLANK;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_an  <= AN_OFF;
      r_seg <= SEG_OFF;
    end else begin
      r_an  <= w_an_nxt;
      r_seg <= w_seg_nxt;
    end
  end

  // A write on the wrap cycle wins over the transfer: the older shadow value
  // is dropped and the new one waits for the next wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shd_data  <= '0;
      r_shd_dp    <= '0;
      r_disp_data <= '0;
      r_disp_dp   <= '0;
      r_pending   <= 1'b0;
    end else if (wr_en) begin
      r_shd_data <= wr_data;
      r_shd_dp   <= wr_dp;
      r_pending  <= 1'b1;
    end else if (w_wrap && r_pending) begin
      r_disp_data <= r_shd_data;
      r_disp_dp   <= r_shd_dp;
      r_pending   <= 1'b0;
    end
  end

  assign an      = r_an;
  assign seg     = r_seg;
  assign pending = r_pending;

endmodule

// File: tb/tb_seg_scan.sv
// Bench for seg_scan: an active-low and an active-high instance share all
// inputs and are compared every cycle against a frame-level display model.
module tb_seg_scan;

  logic        clk      = 1'b0;
  logic        rst      = 1'b1;
  logic        scan_src = 1'b0;
  logic        wr_en    = 1'b0;
  logic [31:0] wr_data  = '0;
  logic [7:0]  wr_dp    = '0;
  logic        blank_lz = 1'b0;

  logic [7:0] an_al, seg_al, an_ah, seg_ah;
  logic       pend_al, pend_ah;

  int checks = 0;
  int errors = 0;
  bit scan_en  = 1'b0;
  int scan_cnt = 0;

  always #5 clk = ~clk;

  seg_scan #(.DIGITS(8), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .scan_src(scan_src), .wr_en(wr_en), .wr_data(wr_data),
    .wr_dp(wr_dp), .blank_lz(blank_lz), .an(an_al), .seg(seg_al), .pending(pend_al)
  );

  seg_scan #(.DIGITS(8), .ACTIVE_LOW(1'b0)) dut_ah (
    .clk(clk), .rst(rst), .scan_src(scan_src), .wr_en(wr_en), .wr_data(wr_data),
    .wr_dp(wr_dp), .blank_lz(blank_lz), .an(an_ah), .seg(seg_ah), .pending(pend_ah)
  );

  localparam logic [6:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Model state: scan position, frame/shadow values, recent scan_src samples
  // and the active-high outputs expected after the most recent edge.
  typedef struct packed {
    logic        dead;
    logic [2:0]  digit;
    logic [31:0] disp;
    logic [7:0]  dpm;
    logic [31:0] shd;
    logic [7:0]  shdp;
    logic        pend;
    logic        s1, s2, s3;
    logic [7:0]  e_an;
    logic [7:0]  e_seg;
  } mstate_t;

  mstate_t m;
  logic    wrap_next;

  function automatic mstate_t model_reset();
    mstate_t r = '0;
    r.dead = 1'b1;
    return r;
  endfunction

  function automatic logic [7:0] digit_pattern(input logic [31:0] disp, input logic [7:0] dpm,
                                               input int d, input logic blz);
    logic [31:0] upper;
    logic        blank;
    upper = disp >> (4 * d);
    blank = blz && (d != 0) && (upper == 32'd0);
    return {dpm[d], blank ? 7'h00 : GLYPH[upper[3:0]]};
  endfunction

  function automatic mstate_t model_step(input mstate_t c, input logic sc, input logic we,
                                         input logic [31:0] wd, input logic [7:0] wdp,
                                         input logic blz);
    mstate_t n;
    logic    tick;
    logic    wrap;
    n    = c;
    tick = c.s2 && !c.s3;
    n.s3 = c.s2;
    n.s2 = c.s1;
    n.s1 = sc;
    if (c.dead) begin
      n.e_an  = 8'h00;
      n.e_seg = 8'h00;
    end else begin
      n.e_an  = 8'd1 << c.digit;
      n.e_seg = digit_pattern(c.disp, c.dpm, int'(c.digit), blz);
    end
    wrap = 1'b0;
    if (c.dead) n.dead = 1'b0;
    else if (tick) begin
      n.dead  = 1'b1;
      wrap    = (c.digit == 3'd7);
      n.digit = 3'((int'(c.digit) + 1) % 8);
    end
    if (we) begin
      n.shd  = wd;
      n.shdp = wdp;
      n.pend = 1'b1;
    end else if (wrap && c.pend) begin
      n.disp = c.shd;
      n.dpm  = c.shdp;
      n.pend = 1'b0;
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= model_reset();
    else     m <= model_step(m, scan_src, wr_en, wr_data, wr_dp, blank_lz);
  end

  assign wrap_next = !m.dead && (m.digit == 3'd7) && m.s2 && !m.s3;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t: timed out waiting", name, $time);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("an_al",   an_al,   ~m.e_an);
      check("seg_al",  seg_al,  ~m.e_seg);
      check("pend_al", {7'd0, pend_al}, {7'd0, m.pend});
      check("an_ah",   an_ah,   m.e_an);
      check("seg_ah",  seg_ah,  m.e_seg);
      check("pend_ah", {7'd0, pend_ah}, {7'd0, m.pend});
    end
  end

  task automatic cycle();
    @(negedge clk);
    wr_en = 1'b0;
    if (scan_en) begin
      if (scan_cnt == 0) begin
        scan_src = ~scan_src;
        scan_cnt = $urandom_range(16, 6);
      end else begin
        scan_cnt--;
      end
    end
  endtask

  task automatic set_write(input logic [31:0] d, input logic [7:0] dp);
    wr_en   = 1'b1;
    wr_data = d;
    wr_dp   = dp;
  endtask

  task automatic do_write(input logic [31:0] d, input logic [7:0] dp);
    cycle();
    set_write(d, dp);
  endtask

  task automatic wait_pending_low(input string name);
    bit found = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      cycle();
      if (pend_al == 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) timeout_fail(name);
  endtask

  // Waits for the given anode pattern, then checks the masked segment value.
  task automatic expect_digit(input string name, input bit ah, input logic [7:0] an_want,
                              input logic [7:0] mask, input logic [7:0] want);
    bit found = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      cycle();
      if ((ah ? an_ah : an_al) == an_want) begin
        found = 1'b1;
        break;
      end
    end
    if (found) check(name, (ah ? seg_ah : seg_al) & mask, want & mask);
    else timeout_fail(name);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst     = 1'b0;
    scan_en = 1'b1;

    // Asynchronous reset while a digit is being driven with a write pending.
    do_write(32'hCAFE_0001, 8'h00);
    expect_digit("t1_digit0_pre", 1'b0, 8'hFE, 8'hFF, 8'hC0);
    #2 rst = 1'b1;
    #1;
    check("t1_rst_an_al",   an_al,  8'hFF);
    check("t1_rst_seg_al",  seg_al, 8'hFF);
    check("t1_rst_pend",    {7'd0, pend_al}, 8'h00);
    check("t1_rst_an_ah",   an_ah,  8'h00);
    check("t1_rst_seg_ah",  seg_ah, 8'h00);
    repeat (3) cycle();
    rst = 1'b0;

    // Basic display of 0x12345678.
    do_write(32'h1234_5678, 8'h00);
    cycle();
    check("t2_pending_set", {7'd0, pend_al}, 8'h01);
    wait_pending_low("t2_wrap");
    expect_digit("t2_digit0_8", 1'b0, 8'hFE, 8'hFF, 8'h80);
    expect_digit("t2_digit7_1", 1'b0, 8'h7F, 8'hFF, 8'hF9);

    // Leading-zero blanking.
    blank_lz = 1'b1;
    do_write(32'h0000_00A0, 8'h00);
    wait_pending_low("t3_wrap_a0");
    expect_digit("t3_digit0_0", 1'b0, 8'hFE, 8'hFF, 8'hC0);
    expect_digit("t3_digit1_A", 1'b0, 8'hFD, 8'hFF, 8'h88);
    expect_digit("t3_digit7_blank", 1'b0, 8'h7F, 8'hFF, 8'hFF);
    do_write(32'h0000_0000, 8'h00);
    wait_pending_low("t3_wrap_0");
    expect_digit("t3z_digit0_0", 1'b0, 8'hFE, 8'hFF, 8'hC0);
    expect_digit("t3z_digit1_blank", 1'b0, 8'hFD, 8'hFF, 8'hFF);

    // Last write within a frame wins.
    blank_lz = 1'b0;
    wait_pending_low("t4_sync");
    do_write(32'h0000_0001, 8'h00);
    repeat (3) cycle();
    set_write(32'h0000_0002, 8'h00);
    wait_pending_low("t4_wrap");
    expect_digit("t4_digit0_2", 1'b0, 8'hFE, 8'hFF, 8'hA4);
    expect_digit("t4_digit1_0", 1'b0, 8'hFD, 8'hFF, 8'hC0);

    // Write coincident with the wrap cycle defers to the next wrap.
    do_write(32'h0000_0003, 8'h00);
    begin
      bit found = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        cycle();
        if (wrap_next) begin
          found = 1'b1;
          break;
        end
      end
      if (!found) timeout_fail("t5_find_wrap");
    end
    set_write(32'h0000_0009, 8'h00);
    cycle();
    check("t5_pending_hold", {7'd0, pend_al}, 8'h01);
    expect_digit("t5_digit0_old", 1'b0, 8'hFE, 8'hFF, 8'hA4);
    wait_pending_low("t5_wrap2");
    expect_digit("t5_digit0_9", 1'b0, 8'hFE, 8'hFF, 8'h90);

    // Decimal points on the active-high instance.
    do_write(32'h1234_5678, 8'h81);
    wait_pending_low("t6_wrap");
    expect_digit("t6_dp0_ah", 1'b1, 8'h01, 8'h80, 8'h80);
    expect_digit("t6_dp1_ah", 1'b1, 8'h02, 8'h80, 8'h00);
    expect_digit("t6_dp7_ah", 1'b1, 8'h80, 8'h80, 8'h80);

    // A sub-cycle glitch on scan_src must not advance the scan.
    expect_digit("t6_digit0_al", 1'b0, 8'hFE, 8'hFF, 8'h00);
    scan_en  = 1'b0;
    scan_src = 1'b0;
    repeat (6) cycle();
    check("t6_hold_an", an_al, 8'hFE);
    @(negedge clk);
    #1 scan_src = 1'b1;
    #3 scan_src = 1'b0;
    repeat (10) cycle();
    check("t6_glitch_an_al", an_al, 8'hFE);
    check("t6_glitch_an_ah", an_ah, 8'h01);

    // Randomised traffic, including writes on wrap cycles and a mid-run reset.
    scan_en = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      cycle();
      if (i == 2000) begin
        #2 rst = 1'b1;
        #1;
        check("rnd_rst_an", an_al, 8'hFF);
        check("rnd_rst_seg", seg_al, 8'hFF);
        repeat (2) cycle();
        rst = 1'b0;
      end else if (($urandom_range(99) == 0) || (wrap_next && $urandom_range(3) == 0)) begin
        set_write($urandom >> $urandom_range(31, 0), 8'($urandom));
      end
      if ($urandom_range(299) == 0) blank_lz = ~blank_lz;
    end

    repeat (4) cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog at %0t: bench did not complete", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
